tl_param_queue: RTL and testbench
=================================

# tl_param_queue

Parametrised ready/valid FIFO for one TileLink A-channel-style beat stream (opcode/param/size/source/address/mask/data/corrupt), the next generation of the fixed 2-entry, 64-bit channel queue. It adds configurable depth and field widths, a FLOW bypass mode, a PIPE mode and an occupancy count. It sits between TileLink producers and consumers as a decoupling or retiming buffer.

## Interface
- DEPTH, 2, number of entries; ≥1, need not be a power of two
- DATA_W, 64, data width; multiple of 8; mask width = DATA_W/8
- ADDR_W, 13, address width
- SOURCE_W, 6, source-ID width
- FLOW, 0, 1 = empty queue combinationally passes enq to deq
- PIPE, 0, 1 = enq_ready also asserted when full and io_deq_ready=1
- CNT_W (derived), clog2(DEPTH+1)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- io_enq_valid / io_enq_ready  in / out  1  producer handshake
- io_enq_bits_opcode, _param, _size  in  3 each
- io_enq_bits_source  in  SOURCE_W
- io_enq_bits_address  in  ADDR_W
- io_enq_bits_mask  in  DATA_W/8
- io_enq_bits_data  in  DATA_W
- io_enq_bits_corrupt  in  1
- io_deq_valid / io_deq_ready  out / in  1  consumer handshake
- io_deq_bits_*  out  same widths as enq fields
- io_count  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH entries of a packed word {corrupt, data, mask, address, source, size, param, opcode}, opcode at LSB. Storage is not reset.
- State: enq_ptr and deq_ptr, each max(1,clog2(DEPTH)) bits, plus maybe_full. A pointer increments on its fire and wraps DEPTH-1 → 0. When DEPTH=1, both pointers stay 0.
- ptr_match = (enq_ptr == deq_ptr).
  - empty = ptr_match & ~maybe_full
  - full = ptr_match & maybe_full
- Base handshake:
  - io_enq_ready = ~full
  - io_deq_valid = ~empty
  - do_enq = io_enq_valid & io_enq_ready
  - do_deq = io_deq_valid & io_deq_ready
- io_deq_bits = storage[deq_ptr], read combinationally with no read-enable gating.
- On do_enq, write storage[enq_ptr].
- maybe_full <= do_enq whenever do_enq != do_deq; otherwise it holds.
- PIPE=1: io_enq_ready = ~full | io_deq_ready. When full, the enqueue and dequeue fire together and count stays DEPTH.
- FLOW=1, while empty:
  - io_deq_valid = io_enq_valid and io_deq_bits = io_enq_bits (combinational bypass).
  - If io_deq_ready=1, the beat passes through. No storage write, no pointer or maybe_full change; do_enq and do_deq are both suppressed internally.
  - If io_deq_ready=0, the beat is written normally.
- io_count = DEPTH when full; otherwise (enq_ptr − deq_ptr) mod DEPTH. The modulo is computed with an explicit +DEPTH correction when enq_ptr < deq_ptr, not by natural wrap, so non-power-of-two DEPTH is correct.
- Simultaneous enq and deq when neither empty nor full: both pointers advance, maybe_full holds, count unchanged.
- Data written this cycle is visible on io_deq_bits no earlier than the next cycle, except through the FLOW bypass.

## Timing
- Latency enq→deq is 1 cycle (FLOW=0). It is 0 cycles under FLOW bypass when empty.
- Throughput is 1 beat/cycle in both directions.
- Reset is asynchronous assert and synchronous-to-clock deassert at the system level. While reset is high:
  - enq_ptr = deq_ptr = 0, maybe_full = 0
  - io_enq_ready = 1, io_deq_valid = 0 (FLOW=1: io_deq_valid follows io_enq_valid), io_count = 0
- Reset asserted mid-operation discards all contents immediately, independent of clock. Stale storage is never presented as valid.
- io_enq_ready depends on io_deq_ready only when PIPE=1. io_deq_valid depends on io_enq_valid only when FLOW=1. No other combinational input→output paths exist except io_deq_bits ← io_enq_bits under FLOW bypass.
- Producers must not depend on io_enq_ready to drive io_enq_valid (TileLink rule). The block holds no assertion on it.

## Test plan
- DEPTH=2, defaults: enqueue beats A (opcode 4, source 0x11, address 0x0040, data 0xDEADBEEF_00000001) and B with deq_ready=0.
  - Required: count 1 then 2, enq_ready drops to 0 after B.
  - Then deq_ready=1: A then B out on consecutive cycles, all fields exact, count returns 0, deq_valid=0.
- DEPTH=3 (non-power-of-two): stream 10 beats with data = index, toggling deq_ready in a 2-on/1-off pattern.
  - Required: in-order output 0..9, pointers wrap 2→0, count never exceeds 3 and matches a scoreboard every cycle.
- PIPE=1, DEPTH=2 full: assert enq_valid and deq_ready in the same cycle.
  - Required: enq_ready=1, one beat in and one out, count stays 2, order preserved.
- FLOW=1, empty: enq_valid=1 with data 0x55 and deq_ready=1.
  - Required: deq_valid=1 and deq_bits_data=0x55 in the same cycle, count stays 0.
  - Repeat with deq_ready=0: count becomes 1 and the beat is delivered on the next cycle.
- Async reset: with 2 beats queued, pulse reset between clock edges.
  - Required: immediately count=0, deq_valid=0, enq_ready=1.
  - After release, a new beat enqueues to entry 0 and dequeues correctly.
- DEPTH=1, DATA_W=32 (mask 4 bits): alternate enq/deq.
  - Required: enq_ready toggles 1/0, max throughput 1 beat per 2 cycles with FLOW=0 and PIPE=0, 1 beat/cycle with PIPE=1.

Source files
------------

// File: rtl/tl_param_queue.sv
// rtl/tl_param_queue.sv - parametrised TileLink A-channel beat queue with FLOW/PIPE modes
module tl_param_queue #(
  parameter int DEPTH    = 2,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 13,
  parameter int SOURCE_W = 6,
  parameter int FLOW     = 0,
  parameter int PIPE     = 0,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int MASK_W  = DATA_W / 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_enq_valid,
  output logic                io_enq_ready,
  input  logic [2:0]          io_enq_bits_opcode,
  input  logic [2:0]          io_enq_bits_param,
  input  logic [2:0]          io_enq_bits_size,
  input  logic [SOURCE_W-1:0] io_enq_bits_source,
  input  logic [ADDR_W-1:0]   io_enq_bits_address,
  input  logic [MASK_W-1:0]   io_enq_bits_mask,
  input  logic [DATA_W-1:0]   io_enq_bits_data,
  input  logic                io_enq_bits_corrupt,
  output logic                io_deq_valid,
  input  logic                io_deq_ready,
  output logic [2:0]          io_deq_bits_opcode,
  output logic [2:0]          io_deq_bits_param,
  output logic [2:0]          io_deq_bits_size,
  output logic [SOURCE_W-1:0] io_deq_bits_source,
  output logic [ADDR_W-1:0]   io_deq_bits_address,
  output logic [MASK_W-1:0]   io_deq_bits_mask,
  output logic [DATA_W-1:0]   io_deq_bits_data,
  output logic                io_deq_bits_corrupt,
  output logic [CNT_W-1:0]    io_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORD_W = 10 + SOURCE_W + ADDR_W + MASK_W + DATA_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic FLOW_EN = (FLOW != 0);
  localparam logic PIPE_EN = (PIPE != 0);

  logic [WORD_W-1:0] ram [DEPTH];
  logic [PTR_W-1:0]  enq_ptr, deq_ptr;
  logic              maybe_full;
  logic              ptr_match, empty, full, bypass, do_enq, do_deq;
  logic [WORD_W-1:0] enq_word, deq_word;
  logic [CNT_W-1:0]  cnt_enq, cnt_deq;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign enq_word = {io_enq_bits_corrupt, io_enq_bits_data, io_enq_bits_mask,
                     io_enq_bits_address, io_enq_bits_source, io_enq_bits_size,
                     io_enq_bits_param, io_enq_bits_opcode};

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;
  assign bypass    = FLOW_EN & empty;

  assign io_enq_ready = ~full | (PIPE_EN & io_deq_ready);
  assign io_deq_valid = bypass ? io_enq_valid : ~empty;

  // A beat taken straight through the bypass never touches storage or pointers.
  assign do_enq = io_enq_valid & io_enq_ready & ~(bypass & io_deq_ready);
  assign do_deq = io_deq_ready & ~empty;

  assign deq_word = bypass ? enq_word : ram[deq_ptr];
  assign {io_deq_bits_corrupt, io_deq_bits_data, io_deq_bits_mask,
          io_deq_bits_address, io_deq_bits_source, io_deq_bits_size,
          io_deq_bits_param, io_deq_bits_opcode} = deq_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) enq_ptr <= bump(enq_ptr);
      if (do_deq) deq_ptr <= bump(deq_ptr);
      if (do_enq != do_deq) maybe_full <= do_enq;
    end
  end

  always_ff @(posedge clock) begin
    if (do_enq) ram[enq_ptr] <= enq_word;
  end

  assign cnt_enq = CNT_W'(enq_ptr);
  assign cnt_deq = CNT_W'(deq_ptr);

  // Explicit wrap correction keeps the count right for non-power-of-two depths.
  always_comb begin
    io_count = '0;
    if (full)
      io_count = CNT_W'(DEPTH);
    else if (enq_ptr >= deq_ptr)
      io_count = cnt_enq - cnt_deq;
    else
      io_count = cnt_enq + CNT_W'(DEPTH) - cnt_deq;
  end

endmodule

// File: tb/tb_tl_param_queue.sv
// tb/tb_tl_param_queue.sv - queue-model bench over six tl_param_queue configurations
module tb_tl_param_queue;

  typedef struct packed {
    logic        cor;
    logic [63:0] dat;
    logic [7:0]  msk;
    logic [12:0] adr;
    logic [5:0]  src;
    logic [2:0]  sz;
    logic [2:0]  pa;
    logic [2:0]  op;
  } beat_t;

  // Instances: 0 D2, 1 D3, 2 D2 PIPE, 3 D2 FLOW, 4 D1 W32, 5 D1 W32 PIPE
  int dep_t [6] = '{2, 3, 2, 2, 1, 1};
  int flw_t [6] = '{0, 0, 0, 1, 0, 0};
  int pip_t [6] = '{0, 0, 1, 0, 0, 1};

  logic        clock, reset;
  logic [2:0]  sel;
  logic        ev, dr;
  beat_t       in_b;
  logic [5:0]  ev_v, dr_v;

  logic        o_er [6], o_dv [6], o_cor [6];
  logic [2:0]  o_op [6], o_pa [6], o_sz [6];
  logic [5:0]  o_src [6];
  logic [12:0] o_adr [6];
  logic [7:0]  o_msk [4];
  logic [63:0] o_dat [4];
  logic [1:0]  o_cnt [4];
  logic [3:0]  w_msk [2];
  logic [31:0] w_dat [2];
  logic [0:0]  w_cnt [2];

  logic  m_er, m_dv;
  int    m_cnt;
  beat_t m_beat;

  beat_t q [$];
  logic [63:0] dlog [$];
  int    total = 0, bad = 0, ndeq = 0, maxc = 0;
  logic  last_er, last_dv, last_efire, last_dfire;
  int    last_cnt;
  beat_t last_beat;

  assign ev_v = {5'b0, ev} << sel;
  assign dr_v = {5'b0, dr} << sel;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  tl_param_queue u_d2 (
    .clock(clock), .reset(reset), .io_enq_valid(ev_v[0]), .io_enq_ready(o_er[0]),
    .io_enq_bits_opcode(in_b.op), .io_enq_bits_param(in_b.pa), .io_enq_bits_size(in_b.sz),
    .io_enq_bits_source(in_b.src), .io_enq_bits_address(in_b.adr),
    .io_enq_bits_mask(in_b.msk), .io_enq_bits_data(in_b.dat), .io_enq_bits_corrupt(in_b.cor),
    .io_deq_valid(o_dv[0]), .io_deq_ready(dr_v[0]),
    .io_deq_bits_opcode(o_op[0]), .io_deq_bits_param(o_pa[0]), .io_deq_bits_size(o_sz[0]),
    .io_deq_bits_source(o_src[0]), .io_deq_bits_address(o_adr[0]),
    .io_deq_bits_mask(o_msk[0]), .io_deq_bits_data(o_dat[0]), .io_deq_bits_corrupt(o_cor[0]),
    .io_count(o_cnt[0]));

  tl_param_queue #(.DEPTH(3)) u_d3 (
    .clock(clock), .reset(reset), .io_enq_valid(ev_v[1]), .io_enq_ready(o_er[1]),
    .io_enq_bits_opcode(in_b.op), .io_enq_bits_param(in_b.pa), .io_enq_bits_size(in_b.sz),
    .io_enq_bits_source(in_b.src), .io_enq_bits_address(in_b.adr),
    .io_enq_bits_mask(in_b.msk), .io_enq_bits_data(in_b.dat), .io_enq_bits_corrupt(in_b.cor),
    .io_deq_valid(o_dv[1]), .io_deq_ready(dr_v[1]),
    .io_deq_bits_opcode(o_op[1]), .io_deq_bits_param(o_pa[1]), .io_deq_bits_size(o_sz[1]),
    .io_deq_bits_source(o_src[1]), .io_deq_bits_address(o_adr[1]),
    .io_deq_bits_mask(o_msk[1]), .io_deq_bits_data(o_dat[1]), .io_deq_bits_corrupt(o_cor[1]),
    .io_count(o_cnt[1]));

  tl_param_queue #(.PIPE(1)) u_pipe (
    .clock(clock), .reset(reset), .io_enq_valid(ev_v[2]), .io_enq_ready(o_er[2]),
    .io_enq_bits_opcode(in_b.op), .io_enq_bits_param(in_b.pa), .io_enq_bits_size(in_b.sz),
    .io_enq_bits_source(in_b.src), .io_enq_bits_address(in_b.adr),
    .io_enq_bits_mask(in_b.msk), .io_enq_bits_data(in_b.dat), .io_enq_bits_corrupt(in_b.cor),
    .io_deq_valid(o_dv[2]), .io_deq_ready(dr_v[2]),
    .io_deq_bits_opcode(o_op[2]), .io_deq_bits_param(o_pa[2]), .io_deq_bits_size(o_sz[2]),
    .io_deq_bits_source(o_src[2]), .io_deq_bits_address(o_adr[2]),
    .io_deq_bits_mask(o_msk[2]), .io_deq_bits_data(o_dat[2]), .io_deq_bits_corrupt(o_cor[2]),
    .io_count(o_cnt[2]));

  tl_param_queue #(.FLOW(1)) u_flow (
    .clock(clock), .reset(reset), .io_enq_valid(ev_v[3]), .io_enq_ready(o_er[3]),
    .io_enq_bits_opcode(in_b.op), .io_enq_bits_param(in_b.pa), .io_enq_bits_size(in_b.sz),
    .io_enq_bits_source(in_b.src), .io_enq_bits_address(in_b.adr),
    .io_enq_bits_mask(in_b.msk), .io_enq_bits_data(in_b.dat), .io_enq_bits_corrupt(in_b.cor),
    .io_deq_valid(o_dv[3]), .io_deq_ready(dr_v[3]),
    .io_deq_bits_opcode(o_op[3]), .io_deq_bits_param(o_pa[3]), .io_deq_bits_size(o_sz[3]),
    .io_deq_bits_source(o_src[3]), .io_deq_bits_address(o_adr[3]),
    .io_deq_bits_mask(o_msk[3]), .io_deq_bits_data(o_dat[3]), .io_deq_bits_corrupt(o_cor[3]),
    .io_count(o_cnt[3]));

  tl_param_queue #(.DEPTH(1), .DATA_W(32)) u_d1 (
    .clock(clock), .reset(reset), .io_enq_valid(ev_v[4]), .io_enq_ready(o_er[4]),
    .io_enq_bits_opcode(in_b.op), .io_enq_bits_param(in_b.pa), .io_enq_bits_size(in_b.sz),
    .io_enq_bits_source(in_b.src), .io_enq_bits_address(in_b.adr),
    .io_enq_bits_mask(in_b.msk[3:0]), .io_enq_bits_data(in_b.dat[31:0]), .io_enq_bits_corrupt(in_b.cor),
    .io_deq_valid(o_dv[4]), .io_deq_ready(dr_v[4]),
    .io_deq_bits_opcode(o_op[4]), .io_deq_bits_param(o_pa[4]), .io_deq_bits_size(o_sz[4]),
    .io_deq_bits_source(o_src[4]), .io_deq_bits_address(o_adr[4]),
    .io_deq_bits_mask(w_msk[0]), .io_deq_bits_data(w_dat[0]), .io_deq_bits_corrupt(o_cor[4]),
    .io_count(w_cnt[0]));

  tl_param_queue #(.DEPTH(1), .DATA_W(32), .PIPE(1)) u_d1p (
    .clock(clock), .reset(reset), .io_enq_valid(ev_v[5]), .io_enq_ready(o_er[5]),
    .io_enq_bits_opcode(in_b.op), .io_enq_bits_param(in_b.pa), .io_enq_bits_size(in_b.sz),
    .io_enq_bits_source(in_b.src), .io_enq_bits_address(in_b.adr),
    .io_enq_bits_mask(in_b.msk[3:0]), .io_enq_bits_data(in_b.dat[31:0]), .io_enq_bits_corrupt(in_b.cor),
    .io_deq_valid(o_dv[5]), .io_deq_ready(dr_v[5]),
    .io_deq_bits_opcode(o_op[5]), .io_deq_bits_param(o_pa[5]), .io_deq_bits_size(o_sz[5]),
    .io_deq_bits_source(o_src[5]), .io_deq_bits_address(o_adr[5]),
    .io_deq_bits_mask(w_msk[1]), .io_deq_bits_data(w_dat[1]), .io_deq_bits_corrupt(o_cor[5]),
    .io_count(w_cnt[1]));

  always_comb begin
    m_er = o_er[sel];
    m_dv = o_dv[sel];
    m_beat = '0;
    m_beat.op = o_op[sel];
    m_beat.pa = o_pa[sel];
    m_beat.sz = o_sz[sel];
    m_beat.src = o_src[sel];
    m_beat.adr = o_adr[sel];
    m_beat.cor = o_cor[sel];
    if (sel < 3'd4) begin
      m_beat.dat = o_dat[sel[1:0]];
      m_beat.msk = o_msk[sel[1:0]];
      m_cnt = int'(o_cnt[sel[1:0]]);
    end else begin
      m_beat.dat = {32'b0, w_dat[sel[0]]};
      m_beat.msk = {4'b0, w_msk[sel[0]]};
      m_cnt = int'(w_cnt[sel[0]]);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic beat_t trunc(input beat_t b);
    beat_t t = b;
    if (sel >= 3'd4) begin
      t.dat[63:32] = '0;
      t.msk[7:4] = '0;
    end
    return t;
  endfunction

  function automatic beat_t mk(input logic [63:0] d);
    beat_t b;
    b.cor = 1'b0; b.dat = d; b.msk = 8'hFF; b.adr = 13'h0100;
    b.src = 6'h2A; b.sz = 3'd2; b.pa = 3'd0; b.op = 3'd1;
    return b;
  endfunction

  function automatic beat_t rnd();
    beat_t b;
    b.cor = 1'($urandom); b.dat = {$urandom, $urandom}; b.msk = 8'($urandom);
    b.adr = 13'($urandom); b.src = 6'($urandom); b.sz = 3'($urandom);
    b.pa = 3'($urandom); b.op = 3'($urandom);
    return b;
  endfunction

  // One clock of stimulus; the queue model predicts every output at mid-cycle.
  task automatic step(input logic v, input logic r, input beat_t b);
    int n;
    logic edv, eer;
    beat_t cur;
    ev = v; dr = r; in_b = b;
    @(negedge clock);
    cur = trunc(b);
    n = q.size();
    edv = (n > 0) || (flw_t[sel] != 0 && v);
    eer = (n < dep_t[sel]) || (pip_t[sel] != 0 && r);
    chk("count", 128'(m_cnt), 128'(n));
    chk("deq_valid", 128'(m_dv), 128'(edv));
    chk("enq_ready", 128'(m_er), 128'(eer));
    if (edv) chk("deq_bits", 128'(m_beat), 128'((n > 0) ? q[0] : cur));
    last_er = m_er; last_dv = m_dv; last_cnt = m_cnt; last_beat = m_beat;
    if (m_cnt > maxc) maxc = m_cnt;
    last_dfire = edv && r;
    last_efire = v && eer;
    if (last_dfire) begin
      ndeq++;
      dlog.push_back(m_beat.dat);
    end
    if (!(n == 0 && last_dfire)) begin
      if (last_dfire) void'(q.pop_front());
      if (last_efire) q.push_back(cur);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && q.size() > 0; k++) step(1'b0, 1'b1, '0);
  endtask

  beat_t a_b, b_b, c_b, p0, p1, p2;
  int idx;

  initial begin
    a_b = '{cor: 1'b0, dat: 64'hDEADBEEF_00000001, msk: 8'hFF, adr: 13'h0040,
            src: 6'h11, sz: 3'd3, pa: 3'd0, op: 3'd4};
    b_b = '{cor: 1'b1, dat: 64'h01234567_89ABCDEF, msk: 8'h0F, adr: 13'h1FF8,
            src: 6'h22, sz: 3'd2, pa: 3'd5, op: 3'd1};
    c_b = mk(64'hCAFE);
    reset = 1'b1; sel = 3'd0; ev = 1'b0; dr = 1'b0; in_b = '0;
    #3;
    chk("reset_count", 128'(m_cnt), 128'(0));
    chk("reset_deq_valid", 128'(m_dv), 128'(0));
    chk("reset_enq_ready", 128'(m_er), 128'(1));
    @(posedge clock);
    #1 reset = 1'b0;

    // DEPTH=2 fill then drain
    step(1'b1, 1'b0, a_b);
    step(1'b1, 1'b0, b_b);
    chk("d2_count1", 128'(last_cnt), 128'(1));
    step(1'b0, 1'b0, '0);
    chk("d2_count2", 128'(last_cnt), 128'(2));
    chk("d2_full_ready", 128'(last_er), 128'(0));
    step(1'b0, 1'b1, '0);
    chk("d2_out_a", 128'(last_beat), 128'(a_b));
    step(1'b0, 1'b1, '0);
    chk("d2_out_b", 128'(last_beat), 128'(b_b));
    step(1'b0, 1'b0, '0);
    chk("d2_empty_valid", 128'(last_dv), 128'(0));

    // Asynchronous reset between edges with two beats queued
    step(1'b1, 1'b0, a_b);
    step(1'b1, 1'b0, b_b);
    ev = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("arst_count", 128'(m_cnt), 128'(0));
    chk("arst_deq_valid", 128'(m_dv), 128'(0));
    chk("arst_enq_ready", 128'(m_er), 128'(1));
    #1 reset = 1'b0;
    q.delete();
    step(1'b1, 1'b0, c_b);
    step(1'b0, 1'b1, '0);
    chk("arst_new_beat", 128'(last_beat), 128'(c_b));
    drain();

    // DEPTH=3 stream of 10 indexed beats, deq_ready 2-on/1-off
    sel = 3'd1; idx = 0; ndeq = 0; maxc = 0; dlog.delete();
    for (int c = 0; c < 80 && ndeq < 10; c++) begin
      step(idx < 10, (c % 3) != 2, mk(64'(idx)));
      if (last_efire) idx++;
    end
    chk("d3_delivered", 128'(ndeq), 128'(10));
    chk("d3_max_count_ok", 128'(maxc <= 3), 128'(1));
    for (int i = 0; i < 10 && i < dlog.size(); i++) chk("d3_order", 128'(dlog[i]), 128'(i));
    drain();

    // PIPE full: simultaneous in and out
    sel = 3'd2; p0 = mk(64'hA0); p1 = mk(64'hA1); p2 = mk(64'hA2);
    step(1'b1, 1'b0, p0);
    step(1'b1, 1'b0, p1);
    step(1'b1, 1'b1, p2);
    chk("pipe_ready_full", 128'(last_er), 128'(1));
    chk("pipe_out_p0", 128'(last_beat), 128'(p0));
    step(1'b0, 1'b0, '0);
    chk("pipe_count", 128'(last_cnt), 128'(2));
    chk("pipe_head_p1", 128'(last_beat), 128'(p1));
    drain();

    // FLOW bypass when empty
    sel = 3'd3;
    step(1'b1, 1'b1, mk(64'h55));
    chk("flow_valid", 128'(last_dv), 128'(1));
    chk("flow_data", 128'(last_beat.dat), 128'(64'h55));
    step(1'b0, 1'b0, '0);
    chk("flow_count0", 128'(last_cnt), 128'(0));
    step(1'b1, 1'b0, mk(64'h55));
    step(1'b0, 1'b1, '0);
    chk("flow_count1", 128'(last_cnt), 128'(1));
    chk("flow_late_data", 128'(last_beat.dat), 128'(64'h55));
    drain();

    // DEPTH=1 throughput, plain then PIPE
    sel = 3'd4; ndeq = 0;
    repeat (8) step(1'b1, 1'b1, rnd());
    chk("d1_throughput", 128'(ndeq), 128'(4));
    drain();
    sel = 3'd5; ndeq = 0;
    repeat (8) step(1'b1, 1'b1, rnd());
    chk("d1_pipe_throughput", 128'(ndeq), 128'(7));
    drain();

    // Random traffic on every configuration
    for (int s = 0; s < 6; s++) begin
      sel = 3'(s);
      repeat (150) step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, rnd());
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
